// File: rtl/ad_line_timing_gen.sv
// Line/frame timing generator driving line/frame valid and SOL/EOL sync words pre-aligned
// for the downstream latch stage. Define AD_SYNC_BLANK_LINE_EN to emit blank-line sequences.
module ad_line_timing_gen #(
    parameter int unsigned SYNC_LEN  = 4,
    parameter int unsigned LATCH_DLY = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] iv_h_total,
    input  logic [CNT_W-1:0] iv_h_start,
    input  logic [CNT_W-1:0] iv_h_len,
    input  logic [CNT_W-1:0] iv_v_total,
    input  logic [CNT_W-1:0] iv_v_active,
    input  logic [15:0]      iv_sync1,
    input  logic [15:0]      iv_sync2,
    input  logic [15:0]      iv_sync3,
    input  logic [15:0]      iv_sol_code,
    input  logic [15:0]      iv_eol_code,
    input  logic [15:0]      iv_blank_code,
    output logic             o_line_valid,
    output logic             o_frame_valid,
    output logic             o_sync_word_sel,
    output logic [15:0]      ov_sync_word,
    output logic             o_cfg_err
);
    localparam int unsigned SW = CNT_W + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP_PEND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, h_start_q, h_start_d, h_len_q, h_len_d;
    logic [CNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
    logic             line_valid_q, line_valid_d, frame_valid_q, frame_valid_d;
    logic             sync_word_sel_q, sync_word_sel_d, cfg_err_q, cfg_err_d;
    logic [15:0]      sync_word_q, sync_word_d;

    logic             live_ok, last_h, last_v, run_d, active;
    logic [SW-1:0]    h_ext, hs_ext, he_ext, sol_lo, eol_lo;
    logic             in_sol, in_eol, seq;
    logic [1:0]       k;
    logic [15:0]      term, word;

    function automatic logic cfg_ok(input logic [CNT_W-1:0] ht, input logic [CNT_W-1:0] hs,
                                    input logic [CNT_W-1:0] hl, input logic [CNT_W-1:0] vt,
                                    input logic [CNT_W-1:0] va);
        logic [SW-1:0] need;
        need = SW'(hs) + SW'(hl) + SW'(SYNC_LEN + LATCH_DLY);
        return (hs >= CNT_W'(SYNC_LEN)) && (hl != '0) && (SW'(ht) >= need) &&
               (va != '0) && (va <= vt);
    endfunction

`ifndef AD_SYNC_BLANK_LINE_EN
    logic unused_blank;
    assign unused_blank = ^iv_blank_code;
`endif

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        v_d        = v_q;
        h_total_d  = h_total_q;
        h_start_d  = h_start_q;
        h_len_d    = h_len_q;
        v_total_d  = v_total_q;
        v_active_d = v_active_q;
        cfg_err_d  = cfg_err_q;

        live_ok = cfg_ok(iv_h_total, iv_h_start, iv_h_len, iv_v_total, iv_v_active);
        last_h  = (h_q == h_total_q - CNT_W'(1));
        last_v  = (v_q == v_total_q - CNT_W'(1));

        // Sequencing and shadow capture; outputs below are derived from the next-cycle view.
        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (i_enable) begin
                    h_total_d  = iv_h_total;
                    h_start_d  = iv_h_start;
                    h_len_d    = iv_h_len;
                    v_total_d  = iv_v_total;
                    v_active_d = iv_v_active;
                    cfg_err_d  = !live_ok;
                    if (live_ok) state_d = ST_RUN;
                end
            end
            ST_RUN, ST_STOP_PEND: begin
                if (state_q == ST_RUN && !i_enable) state_d = ST_STOP_PEND;
                if (last_h) begin
                    h_d = '0;
                    if (last_v) begin
                        v_d = '0;
                        if (state_q == ST_RUN && i_enable) begin
                            h_total_d  = iv_h_total;
                            h_start_d  = iv_h_start;
                            h_len_d    = iv_h_len;
                            v_total_d  = iv_v_total;
                            v_active_d = iv_v_active;
                            cfg_err_d  = !live_ok;
                            state_d    = live_ok ? ST_RUN : ST_IDLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        v_d = v_q + CNT_W'(1);
                    end
                end else begin
                    h_d = h_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        run_d  = (state_d != ST_IDLE);
        active = (v_d < v_active_d);
        h_ext  = SW'(h_d);
        hs_ext = SW'(h_start_d);
        he_ext = hs_ext + SW'(h_len_d);
        sol_lo = hs_ext - SW'(SYNC_LEN) + SW'(LATCH_DLY);
        eol_lo = he_ext + SW'(LATCH_DLY);
        in_sol = (h_ext >= sol_lo) && (h_ext < sol_lo + SW'(SYNC_LEN));
        in_eol = (h_ext >= eol_lo) && (h_ext < eol_lo + SW'(SYNC_LEN));

        line_valid_d  = run_d && active && (h_ext >= hs_ext) && (h_ext < he_ext);
        frame_valid_d = run_d && active;

        seq  = 1'b0;
        k    = 2'(h_ext - sol_lo);
        term = iv_sol_code;
        if (run_d && active && in_sol) begin
            seq = 1'b1;
        end else if (run_d && active && in_eol) begin
            seq  = 1'b1;
            k    = 2'(h_ext - eol_lo);
            term = iv_eol_code;
        end
`ifdef AD_SYNC_BLANK_LINE_EN
        else if (run_d && !active && in_sol) begin
            seq  = 1'b1;
            term = iv_blank_code;
        end
`endif
        case (k)
            2'd0:    word = iv_sync1;
            2'd1:    word = iv_sync2;
            2'd2:    word = iv_sync3;
            default: word = term;
        endcase
        sync_word_sel_d = seq;
        sync_word_d     = seq ? word : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            h_q             <= '0;
            v_q             <= '0;
            h_total_q       <= '0;
            h_start_q       <= '0;
            h_len_q         <= '0;
            v_total_q       <= '0;
            v_active_q      <= '0;
            line_valid_q    <= 1'b0;
            frame_valid_q   <= 1'b0;
            sync_word_sel_q <= 1'b0;
            sync_word_q     <= 16'h0000;
            cfg_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            h_q             <= h_d;
            v_q             <= v_d;
            h_total_q       <= h_total_d;
            h_start_q       <= h_start_d;
            h_len_q         <= h_len_d;
            v_total_q       <= v_total_d;
            v_active_q      <= v_active_d;
            line_valid_q    <= line_valid_d;
            frame_valid_q   <= frame_valid_d;
            sync_word_sel_q <= sync_word_sel_d;
            sync_word_q     <= sync_word_d;
            cfg_err_q       <= cfg_err_d;
        end
    end

    assign o_line_valid    = line_valid_q;
    assign o_frame_valid   = frame_valid_q;
    assign o_sync_word_sel = sync_word_sel_q;
    assign ov_sync_word    = sync_word_q;
    assign o_cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_ad_line_timing_gen.sv
// Directed self-checking bench for ad_line_timing_gen; honours AD_SYNC_BLANK_LINE_EN.
module tb_ad_line_timing_gen;
    localparam logic [15:0] S1  = 16'hA001;
    localparam logic [15:0] S2  = 16'hA002;
    localparam logic [15:0] S3  = 16'hA003;
    localparam logic [15:0] SOL = 16'h5A01;
    localparam logic [15:0] EOL = 16'h5A02;
    localparam logic [15:0] BLK = 16'h5A03;

    logic        clk, reset, i_enable;
    logic [15:0] iv_h_total, iv_h_start, iv_h_len, iv_v_total, iv_v_active;
    logic        o_line_valid, o_frame_valid, o_sync_word_sel, o_cfg_err;
    logic [15:0] ov_sync_word;
    int          total, bad;

    ad_line_timing_gen dut (
        .clk(clk), .reset(reset), .i_enable(i_enable),
        .iv_h_total(iv_h_total), .iv_h_start(iv_h_start), .iv_h_len(iv_h_len),
        .iv_v_total(iv_v_total), .iv_v_active(iv_v_active),
        .iv_sync1(S1), .iv_sync2(S2), .iv_sync3(S3),
        .iv_sol_code(SOL), .iv_eol_code(EOL), .iv_blank_code(BLK),
        .o_line_valid(o_line_valid), .o_frame_valid(o_frame_valid),
        .o_sync_word_sel(o_sync_word_sel), .ov_sync_word(ov_sync_word),
        .o_cfg_err(o_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] seqw(input int k, input logic [15:0] term);
        case (k)
            0:       return S1;
            1:       return S2;
            2:       return S3;
            default: return term;
        endcase
    endfunction

    // Expected {lv, fv, sel, word} for h_len=8, v_active=2 with the given h_start.
    function automatic logic [18:0] exp_out(input int h, input int v, input int hs);
        logic lv, fv, sel;
        logic [15:0] w;
        lv  = (v < 2) && (h >= hs) && (h <= hs + 7);
        fv  = (v < 2);
        sel = 1'b0;
        w   = 16'h0;
        if (v < 2 && h >= hs - 2 && h <= hs + 1) begin
            sel = 1'b1; w = seqw(h - (hs - 2), SOL);
        end else if (v < 2 && h >= hs + 10 && h <= hs + 13) begin
            sel = 1'b1; w = seqw(h - (hs + 10), EOL);
        end
`ifdef AD_SYNC_BLANK_LINE_EN
        else if (v >= 2 && h >= hs - 2 && h <= hs + 1) begin
            sel = 1'b1; w = seqw(h - (hs - 2), BLK);
        end
`endif
        return {lv, fv, sel, w};
    endfunction

    task automatic set_nominal();
        iv_h_total = 16'd32; iv_h_start = 16'd6; iv_h_len = 16'd8;
        iv_v_total = 16'd4;  iv_v_active = 16'd2;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        set_nominal();
        i_enable = 1'b1;
        reset    = 1'b1;
        step(); step();
        got = {o_line_valid, o_frame_valid, o_sync_word_sel, o_cfg_err, ov_sync_word};
        total++;
        if (got !== 20'h0) begin bad++; $display("FAIL reset_hold got=%h exp=%h", got, 20'h0); end
        i_enable = 1'b0;
        reset    = 1'b0;
        step(); step();
        got = {o_line_valid, o_frame_valid, o_sync_word_sel, o_cfg_err, ov_sync_word};
        total++;
        if (got !== 20'h0) begin bad++; $display("FAIL idle_no_enable got=%h exp=%h", got, 20'h0); end
    endtask

    task automatic test_nominal();
        logic [18:0] got, exp;
        set_nominal();
        i_enable = 1'b1;
        step();
        for (int c = 0; c < 256; c++) begin
            got = {o_line_valid, o_frame_valid, o_sync_word_sel, ov_sync_word};
            exp = exp_out(c % 32, (c / 32) % 4, 6);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL nominal c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 0) begin
                total++;
                if (o_cfg_err !== 1'b0) begin bad++; $display("FAIL nominal_cfg_err got=%b exp=0", o_cfg_err); end
            end
            step();
        end
    endtask

    task automatic test_enable_drop();
        logic [18:0] got, exp;
        for (int c = 0; c < 168; c++) begin
            got = {o_line_valid, o_frame_valid, o_sync_word_sel, ov_sync_word};
            exp = (c < 128) ? exp_out(c % 32, c / 32, 6) : 19'h0;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL enable_drop c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 42) i_enable = 1'b0;
            step();
        end
    endtask

    task automatic test_shadow();
        logic [18:0] got, exp;
        set_nominal();
        i_enable = 1'b1;
        step();
        for (int c = 0; c < 256; c++) begin
            got = {o_line_valid, o_frame_valid, o_sync_word_sel, ov_sync_word};
            exp = exp_out(c % 32, (c / 32) % 4, (c < 128) ? 6 : 8);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL shadow c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 40) iv_h_start = 16'd8;
            step();
        end
        i_enable = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        set_nominal();
    endtask

    task automatic test_reset_mid();
        logic [18:0] got, exp;
        logic [19:0] all;
        set_nominal();
        i_enable = 1'b1;
        step();
        for (int c = 0; c < 6; c++) begin
            got = {o_line_valid, o_frame_valid, o_sync_word_sel, ov_sync_word};
            exp = exp_out(c, 0, 6);
            total++;
            if (got !== exp) begin bad++; $display("FAIL pre_reset c=%0d got=%h exp=%h", c, got, exp); end
            if (c < 5) step();
        end
        reset = 1'b1;
        step();
        all = {o_line_valid, o_frame_valid, o_sync_word_sel, o_cfg_err, ov_sync_word};
        total++;
        if (all !== 20'h0) begin bad++; $display("FAIL reset_mid got=%h exp=%h", all, 20'h0); end
        reset = 1'b0;
        step();
        for (int c = 0; c < 41; c++) begin
            got = {o_line_valid, o_frame_valid, o_sync_word_sel, ov_sync_word};
            exp = exp_out(c % 32, c / 32, 6);
            total++;
            if (got !== exp) begin bad++; $display("FAIL restart c=%0d got=%h exp=%h", c, got, exp); end
            step();
        end
        i_enable = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
    endtask

    task automatic test_min_blank();
        logic [19:0] got, exp;
        int h, v;
        logic lv, fv, sel;
        logic [15:0] w;
        iv_h_total = 16'd18; iv_h_start = 16'd4; iv_h_len = 16'd8;
        iv_v_total = 16'd2;  iv_v_active = 16'd1;
        i_enable = 1'b1;
        step();
        for (int c = 0; c < 36; c++) begin
            h = c % 18; v = (c / 18) % 2;
            lv = (v == 0) && (h >= 4) && (h <= 11);
            fv = (v == 0);
            sel = 1'b0; w = 16'h0;
            if (v == 0 && h >= 2 && h <= 5) begin sel = 1'b1; w = seqw(h - 2, SOL); end
            else if (v == 0 && h >= 14) begin sel = 1'b1; w = seqw(h - 14, EOL); end
`ifdef AD_SYNC_BLANK_LINE_EN
            else if (v == 1 && h >= 2 && h <= 5) begin sel = 1'b1; w = seqw(h - 2, BLK); end
`endif
            exp = {lv, fv, sel, 1'b0, w};
            got = {o_line_valid, o_frame_valid, o_sync_word_sel, o_cfg_err, ov_sync_word};
            total++;
            if (got !== exp) begin bad++; $display("FAIL min_blank c=%0d got=%h exp=%h", c, got, exp); end
            step();
        end
        i_enable = 1'b0;
        reset    = 1'b1;
        step();
        reset      = 1'b0;
        iv_h_total = 16'd17;
        i_enable   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            got = {o_line_valid, o_frame_valid, o_sync_word_sel, o_cfg_err, ov_sync_word};
            exp = {4'b0001, 16'h0};
            total++;
            if (got !== exp) begin bad++; $display("FAIL cfg_invalid c=%0d got=%h exp=%h", c, got, exp); end
        end
        iv_h_total = 16'd18;
        step();
        got = {o_line_valid, o_frame_valid, o_sync_word_sel, o_cfg_err, ov_sync_word};
        exp = {4'b0100, 16'h0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL cfg_recover got=%h exp=%h", got, exp); end
        step(); step();
        got = {o_line_valid, o_frame_valid, o_sync_word_sel, o_cfg_err, ov_sync_word};
        exp = {4'b0110, S1};
        total++;
        if (got !== exp) begin bad++; $display("FAIL cfg_recover_sol got=%h exp=%h", got, exp); end
        i_enable = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; i_enable = 1'b0;
        total = 0; bad = 0;
        set_nominal();
        @(negedge clk);
        test_reset();
        test_nominal();
        test_enable_drop();
        test_shadow();
        test_reset_mid();
        test_min_blank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
